// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration path: RAM handshake states,
// arbiter FSM states, grant identity and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating grant-wait counter: clear wins over enable, holds at MAX_WAIT,
// o_sat flags the saturated value.
module arb_wait_counter #(
  parameter int MAX_WAIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] C_MAX = W'(MAX_WAIT);

  logic [W-1:0] r_count;

  assign o_sat = (r_count == C_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the single RAM port to the icache or dcache and returns the data.
// Define ARB_RR_EN to alternate grants under contention (default: data first).
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout,
  output logic        ram_err
);

  arb_state_t r_state, w_next;
  grant_t     r_last_grant, w_last_next;
  logic       r_timeout, r_ram_err;
  logic       w_d_req, w_i_req, w_access, w_error, w_cnt_en, w_err_seen, w_sat;

  assign w_d_req  = dREN | dWEN;
  assign w_i_req  = iREN;
  assign w_access = (ramstate_t'(ramstate) == ACCESS);
  assign w_error  = (ramstate_t'(ramstate) == ERROR);

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_clr (r_state == IDLE),
    .i_en  (w_cnt_en),
    .o_sat (w_sat)
  );

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last_grant;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    w_cnt_en    = 1'b0;
    w_err_seen  = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef ARB_RR_EN
        if (w_d_req && w_i_req) w_next = (r_last_grant == GNT_D) ? IGNT : DGNT;
        else if (w_d_req)       w_next = DGNT;
        else if (w_i_req)       w_next = IGNT;
`else
        if (w_d_req)      w_next = DGNT;
        else if (w_i_req) w_next = IGNT;
`endif
      end
      DGNT: begin
        if (!w_d_req) begin
          w_next = IDLE;  // request withdrawn: abandon without completion
        end else begin
          ramaddr    = daddr;
          ramstore   = dstore;
          ramWEN     = dWEN;
          ramREN     = !dWEN;
          w_err_seen = w_error;
          if (w_access) begin
            dwait       = 1'b0;
            dload       = ramload;
            w_next      = IDLE;
            w_last_next = GNT_D;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      IGNT: begin
        if (!w_i_req) begin
          w_next = IDLE;
        end else begin
          ramaddr    = iaddr;
          ramREN     = 1'b1;
          w_err_seen = w_error;
          if (w_access) begin
            iwait       = 1'b0;
            iload       = ramload;
            w_next      = IDLE;
            w_last_next = GNT_I;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_I;
      r_timeout    <= 1'b0;
      r_ram_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_last_grant <= w_last_next;
      r_timeout    <= r_timeout | w_sat;
      r_ram_err    <= r_ram_err | w_err_seen;
    end
  end

  // Counter saturation shows up in the same cycle it is reached.
  assign timeout = r_timeout | w_sat;
  assign ram_err = r_ram_err;

endmodule
